// File: rtl/var_pick_onehot.sv
// Round-robin free-variable picker: captures an unassigned mask on start and scans
// it one bit per cycle from just after the last pick, returning the winner one-hot.
module var_pick_onehot #(
  parameter int WIDTH   = 8,
  parameter int WIDTH_P = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             ptr_clr_i,
  input  logic [WIDTH-1:0] unassigned_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             found_o,
  output logic [WIDTH-1:0] onehot_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH_P-1:0] PTR_RST = WIDTH_P'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE     = WIDTH'(1);

  state_t             state_r, state_nxt;
  logic [WIDTH-1:0]   mask_r;
  logic [WIDTH_P-1:0] ptr_r, cur_r, cnt_r, ptr_eff;
  logic               hit, last;

  assign hit  = mask_r[cur_r];
  assign last = (cnt_r == PTR_RST);
  // A same-cycle clear wins, so a clear+start scans from bit 0.
  assign ptr_eff = ptr_clr_i ? PTR_RST : ptr_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt;
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    if (start_i) state_nxt = SCAN;
      SCAN:    if (hit || last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_r == SCAN) || (state_r == DONE);
    done_o = (state_r == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r   <= '0;
      ptr_r    <= PTR_RST;
      cur_r    <= '0;
      cnt_r    <= '0;
      onehot_o <= '0;
      found_o  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ptr_r <= ptr_eff;
          if (start_i) begin
            mask_r   <= unassigned_i;
            cur_r    <= ptr_eff + WIDTH_P'(1);
            cnt_r    <= '0;
            onehot_o <= '0;
            found_o  <= 1'b0;
          end
        end
        SCAN: begin
          if (hit) begin
            onehot_o <= ONE << cur_r;
            found_o  <= 1'b1;
            ptr_r    <= cur_r;
          end else if (last) begin
            onehot_o <= '0;
            found_o  <= 1'b0;
          end else begin
            cur_r <= cur_r + WIDTH_P'(1);
            cnt_r <= cnt_r + WIDTH_P'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_var_pick_onehot.sv
// Directed bench for var_pick_onehot: a cycle-level model checked every cycle plus
// hand-computed latency/result expectations per pick.
module tb_var_pick_onehot;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start_i = 1'b0;
  logic         ptr_clr_i = 1'b0;
  logic [W-1:0] unassigned_i = '0;
  logic         busy_o, done_o, found_o;
  logic [W-1:0] onehot_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  var_pick_onehot #(.WIDTH(W), .WIDTH_P(3)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .ptr_clr_i(ptr_clr_i),
    .unassigned_i(unassigned_i), .busy_o(busy_o), .done_o(done_o),
    .found_o(found_o), .onehot_o(onehot_o)
  );

  always #5 clk = ~clk;

  // Model: rem = cycles left in the current pick (busy while >0, done when ==1).
  int           rem = 0;
  int           m_ptr = W - 1;
  int           p_ptr = 0;
  logic         m_found = 1'b0, p_found = 1'b0;
  logic [W-1:0] m_onehot = '0, p_onehot = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem = 0; m_ptr = W - 1; m_found = 1'b0; m_onehot = '0;
    end else if (rem == 0) begin
      if (ptr_clr_i) m_ptr = W - 1;
      if (start_i) begin
        p_found = 1'b0; p_onehot = '0; p_ptr = m_ptr;
        rem = W + 1;
        for (int k = 0; k < W; k++) begin
          int idx;
          idx = (m_ptr + 1 + k) % W;
          if (!p_found && unassigned_i[idx]) begin
            p_found = 1'b1; p_onehot = '0; p_onehot[idx] = 1'b1;
            p_ptr = idx; rem = k + 2;
          end
        end
        m_found = 1'b0; m_onehot = '0;
      end
    end else begin
      rem = rem - 1;
      if (rem == 1) begin
        m_found = p_found; m_onehot = p_onehot;
        if (p_found) m_ptr = p_ptr;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (busy_o !== (rem > 0)) begin
        errors++; $display("FAIL model_busy t=%0t got %b want %b", $time, busy_o, rem > 0);
      end
      checks++;
      if (done_o !== (rem == 1)) begin
        errors++; $display("FAIL model_done t=%0t got %b want %b", $time, done_o, rem == 1);
      end
      checks++;
      if (found_o !== m_found) begin
        errors++; $display("FAIL model_found t=%0t got %b want %b", $time, found_o, m_found);
      end
      checks++;
      if (onehot_o !== m_onehot) begin
        errors++; $display("FAIL model_onehot t=%0t got %h want %h", $time, onehot_o, m_onehot);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++; $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // One pick: start (optionally with clear), wait for done, check against literals.
  task automatic pick(input string name, input logic [W-1:0] mask, input logic clr,
                      input logic [W-1:0] exp_oh, input logic exp_found, input int exp_lat,
                      input bit perturb);
    int lat, busy_cnt;
    lat = 0; busy_cnt = 0;
    start_i = 1'b1; ptr_clr_i = clr; unassigned_i = mask;
    @(posedge clk); #1;
    start_i = 1'b0; ptr_clr_i = 1'b0;
    for (int c = 1; c <= W + 4; c++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (done_o) begin lat = c; break; end
      if (perturb) begin
        start_i = c[0]; ptr_clr_i = c[0]; unassigned_i = 8'h02 ^ W'(c);
      end
    end
    start_i = 1'b0; ptr_clr_i = 1'b0;
    if (lat == 0) begin
      errors++; checks++; $display("FAIL %s_timeout got no done want done", name);
    end else begin
      check({name, "_lat"}, lat, exp_lat);
      check({name, "_busy"}, busy_cnt, exp_lat);
      check({name, "_found"}, int'(found_o), int'(exp_found));
      check({name, "_onehot"}, int'(onehot_o), int'(exp_oh));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_found", int'(found_o), 0);
    check("rst_onehot", int'(onehot_o), 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    pick("post_rst", 8'h01, 1'b0, 8'h01, 1'b1, 2, 1'b0);
    pick("pick2", 8'h04, 1'b0, 8'h04, 1'b1, 3, 1'b0);
    pick("rr_wrap", 8'h05, 1'b0, 8'h01, 1'b1, 7, 1'b0);
    pick("empty", 8'h00, 1'b0, 8'h00, 1'b0, 9, 1'b0);
    // held result after DONE
    check("hold_found", int'(found_o), 0);
    pick("after_empty", 8'hFF, 1'b0, 8'h02, 1'b1, 2, 1'b0);
    pick("to_ptr5", 8'h20, 1'b0, 8'h20, 1'b1, 5, 1'b0);
    pick("clr_start", 8'h81, 1'b1, 8'h01, 1'b1, 2, 1'b0);
    pick("perturb", 8'h10, 1'b0, 8'h10, 1'b1, 5, 1'b1);
    // no second done after the perturbed pick
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("no_extra_done", int'(done_o), 0);
    end

    // Reset mid-scan: clear+start with 0x80 scans from bit 0, then reset in cycle 3.
    @(posedge clk); #1;
    start_i = 1'b1; ptr_clr_i = 1'b1; unassigned_i = 8'h80;
    @(posedge clk); #1;
    start_i = 1'b0; ptr_clr_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_done", int'(done_o), 0);
    check("mid_rst_found", int'(found_o), 0);
    check("mid_rst_onehot", int'(onehot_o), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk); check("mid_rst_no_done", int'(done_o), 0);
    end
    @(posedge clk); #1;
    pick("after_mid_rst", 8'h80, 1'b0, 8'h80, 1'b1, 9, 1'b0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/var_pick_onehot.md
# var_pick_onehot

Round-robin free-variable picker for the SAT engine state list. On a start request it captures a per-variable "unassigned" mask and scans it one bit per cycle, beginning just after the most recently picked variable. It returns the chosen variable as a one-hot vector. That vector feeds the downstream one-hot-to-binary encoder directly, which turns it into the variable index used by the decision logic.

## Interface
- `WIDTH`, default 8: number of variables in the local state list; must be a power of two, ≥2.
- `WIDTH_P`, default 3: log2(`WIDTH`); width of the internal pointer and counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk` — input, 1 bit: single clock; all state changes on its rising edge.
- `rst_n` — input, 1 bit: asynchronous, active-low reset.
- `start_i` — input, 1 bit: request a pick; honoured only in IDLE.
- `ptr_clr_i` — input, 1 bit: return the round-robin pointer to its reset value; honoured only in IDLE.
- `unassigned_i` — input, `WIDTH` bits: bit k = 1 means variable k is free; sampled only on the cycle `start_i` is accepted.
- `busy_o` — output, 1 bit: high while in SCAN or DONE.
- `done_o` — output, 1 bit: one-cycle pulse; the result is valid.
- `found_o` — output, 1 bit: a free variable was found.
- `onehot_o` — output, `WIDTH` bits: the picked variable, exactly one bit set; all zeros when `found_o`=0.

## Operation
- **Registers**
  - `mask_r`: `WIDTH` bits.
  - `ptr_r`: `WIDTH_P` bits; index of the last picked variable.
  - `cur_r`: `WIDTH_P` bits; scan index.
  - `cnt_r`: `WIDTH_P` bits; number of bits already tested.
  - `onehot_o`, `found_o`: registered outputs.
- **FSM states:** IDLE, SCAN, DONE.
- **IDLE**
  - `ptr_clr_i`=1 sets `ptr_r` to `WIDTH`-1.
  - `start_i`=1:
    - `mask_r` ← `unassigned_i`.
    - `cur_r` ← start index. The start index is computed from `ptr_r` after any same-cycle clear, so clear takes effect first and the scan begins at bit 0.
    - Start index = (`ptr_r`+1) mod `WIDTH`, with natural wrap of the `WIDTH_P`-bit add.
    - `cnt_r` ← 0.
    - `onehot_o` ← 0 and `found_o` ← 0.
    - Next state: SCAN.
- **SCAN** (one test per cycle)
  - If `mask_r[cur_r]`=1:
    - `onehot_o` ← 1<<`cur_r`.
    - `found_o` ← 1.
    - `ptr_r` ← `cur_r`.
    - Next state: DONE.
  - Else if `cnt_r`=`WIDTH`-1:
    - `onehot_o` ← 0 and `found_o` ← 0.
    - `ptr_r` unchanged.
    - Next state: DONE.
  - Else: `cur_r` ← `cur_r`+1 (wraps `WIDTH`-1→0), `cnt_r` ← `cnt_r`+1.
- **DONE**
  - `done_o`=1 for this cycle only.
  - Next state: IDLE unconditionally.
- **Ignored inputs**
  - `start_i` and `ptr_clr_i` are ignored in SCAN and DONE; there is no queuing.
  - `unassigned_i` changes after acceptance have no effect.
- **Result holding:** `onehot_o` and `found_o` hold their values after DONE until the next accepted start.
- **Wrap-around:** the scan order is cyclic. Bits above the start index are visited first, then bits 0 up to the start index-1.
- **Reset (async, `rst_n`=0), including mid-scan**
  - State → IDLE.
  - `ptr_r` = `WIDTH`-1.
  - `cur_r`=0, `cnt_r`=0, `mask_r`=0.
  - `onehot_o`=0, `found_o`=0, `done_o`=0, `busy_o`=0.
  - A scan in progress is abandoned and no `done_o` is produced.

## Timing
- `busy_o`=1 is combinational from the state (SCAN or DONE). It is high from cycle 1 through cycle d+2.
- **Found case:** start accepted at edge of cycle 0, with the free bit at cyclic distance d (0..`WIDTH`-1) from the start index.
  - SCAN occupies cycles 1..d+1.
  - `done_o`, `found_o`=1 and `onehot_o` are valid in cycle d+2.
  - Latency: minimum 2 cycles, maximum `WIDTH`+1 cycles.
- **Not-found case:** `done_o` in cycle `WIDTH`+1 with `found_o`=0 and `onehot_o`=0.
- **Back-to-back:** earliest next accepted start is the cycle after DONE (IDLE). Throughput is one pick per d+3 cycles.
- **Downstream:** `onehot_o` is always zero or one-hot, so the downstream encoder never sees its default case except for all zeros (found_o=0).

## Test plan
- **Post-reset pick:** reset, then `start_i` with `unassigned_i`=8'b0000_0001 → `done_o` 2 cycles later, `onehot_o`=8'h01, `found_o`=1, `busy_o` high for 2 cycles.
- **Round robin:** after picking bit 2, start with mask 8'b0000_0101 → `onehot_o`=8'h01 (wrapped), `done_o` at cycle 7.
  - Scan order is 3,4,5,6,7,0, so bit 0 is tested in cycle 6.
- **Empty mask:** start with 8'h00 → `done_o` at cycle 9, `found_o`=0, `onehot_o`=0, pointer unchanged (the next start with 8'hFF picks the bit after the previous pick).
- **Clear vs start:** with `ptr_r`=5, assert `ptr_clr_i` and `start_i` together with mask 8'b1000_0001 → `onehot_o`=8'h01 in cycle 2.
- **Input changes during scan:** toggle `start_i` and change `unassigned_i` during SCAN → no restart, result reflects the captured mask, exactly one `done_o` pulse.
- **Reset mid-scan:** assert `rst_n`=0 in cycle 3 of a scan with mask 8'h80 from start index 0 → all outputs 0 immediately, no `done_o`; the next start with 8'h80 yields `onehot_o`=8'h80 at cycle 9.
